seg7_scan_blink: RTL and testbench
==================================

Name: seg7_scan_blink

Overview:
- Downstream consumer of the shared 2 Hz blink divider in the digital clock.
- Time-multiplexes four BCD digits onto a common 4-anode 7-segment display.
- Blanks selected digits while the blink signal is low, so a digit being set flashes at 2 Hz.
- Inserts an all-anodes-off dead time at the start of each digit slot to suppress ghosting.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (1 kHz slot rate at 50 MHz); must be ≥ 2.
- DEAD_CYCLES, 500, cycles at the start of each slot with all anodes off; 1 ≤ DEAD_CYCLES < SCAN_DIV.
- SEG_ACTIVE_LOW, 1, 1 means seg/dp low = lit.
- ANODE_ACTIVE_LOW, 1, 1 means anode low = digit enabled.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- digits  in  16  {d3,d2,d1,d0}, 4-bit BCD each; d0 = rightmost digit.
- blink_mask  in  4  bit i = 1 means digit i blinks.
- blink  in  1  2 Hz square wave from the blink divider; high = show, low = blank masked digits.
- dp_mask  in  4  bit i = 1 means decimal point lit on digit i.
- anode  out  4  one-hot digit enable, polarity per ANODE_ACTIVE_LOW.
- seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - cnt = 0, idx = 0, data_q = 0, blink_q = 0.
  - anode all inactive (4'b1111 with defaults).
  - seg all dark (7'h7F with defaults); dp dark (1).
- Slot counter:
  - cnt counts 0 to SCAN_DIV-1, then wraps to 0.
  - On wrap, idx advances 0→1→2→3→0. There is no other idx transition.
- Data capture:
  - In every cycle with cnt == 0, including the first cycle after reset releases, capture:
    - data_q ← digits[4*idx+3 : 4*idx]
    - dp_q ← dp_mask[idx]
    - mask_q ← blink_mask[idx]
  - Input changes mid-slot do not affect the current slot.
- Blink:
  - blink_q ← blink every cycle. This register is the synchronising register.
  - Blanking is evaluated every cycle, not per slot. A blink edge therefore reaches seg within 2 clk edges.
- Output registers (all outputs registered, 1-cycle latency from cnt/idx/data_q/blink_q):
  - If cnt < DEAD_CYCLES: anode all inactive, seg dark, dp dark.
  - Else if mask_q && !blink_q: anode = onehot(idx), seg dark, dp dark. The anode scan continues so brightness timing is unchanged.
  - Else: anode = onehot(idx), seg = decode(data_q), dp = dp_q.
- Decode (active-high gfedcba; inverted when SEG_ACTIVE_LOW):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10–15 display a dash (g only, 40).
- Boundary conditions:
  - Reset mid-slot: the next edge restores all reset values. The scan restarts at digit 0 with a full dead time.
  - blink_mask = 0: the blink input is ignored.
  - Simultaneous cnt wrap and input change: the new value is captured in the next cycle (cnt == 0) for the new idx.
- Anode-active invariant:
  - At most one anode is active in any cycle.
  - No two consecutive cycles have different active anodes; at least DEAD_CYCLES dark cycles separate them.

Test Plan (SCAN_DIV=8, DEAD_CYCLES=2, active-low defaults):
1. Reset asserted 3 cycles, then released -> during reset and for the next 2 cycles: anode=1111, seg=7F, dp=1. Then anode=1110 for 6 cycles.
2. digits=16'h1234, masks 0 -> per 8-cycle slot: 2 dark cycles, then 6 cycles of each step in turn:
   - anode=1110, seg=19 (4)
   - anode=1101, seg=30 (3)
   - anode=1011, seg=24 (2)
   - anode=0111, seg=79 (1)
   - repeat.
3. blink_mask=0011, blink=0 -> digits 0 and 1 show seg=7F with their anodes still cycling; digits 2 and 3 unaffected. Raise blink -> digits 0/1 lit within 2 cycles.
4. digits=16'h00A0, dp_mask=0100 -> digit1 seg=3F (dash), digit0 seg=40 (0), digit2 dp=0, all others dp=1.
5. Change digits from 1234 to 5678 at cnt=4 of slot 0 -> slot 0 keeps showing 4; slot 1 shows 7.
6. Assert reset at cnt=5 of slot 2 -> next cycle: anode=1111, seg=7F. After release, the scan starts at anode=1110 after 2 dark cycles.

Source files
------------

// File: rtl/seg7_scan_blink.sv
// seg7_scan_blink: drives a 4-digit common-anode 7-segment display by
// time-multiplexing four BCD digits. Each digit slot opens with a dead time
// (all anodes off) to suppress ghosting. Digits selected by blink_mask go
// dark while the 2 Hz blink input is low.
// SCAN_DIV must be >= 2, and 1 <= DEAD_CYCLES < SCAN_DIV.
module seg7_scan_blink #(
   parameter int SCAN_DIV         = 50000,
   parameter int DEAD_CYCLES      = 500,
   parameter bit SEG_ACTIVE_LOW   = 1'b1,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  blink_mask,
   input  logic        blink,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   localparam logic [3:0] ANODE_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [6:0] SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF    = SEG_ACTIVE_LOW;

   // Slot timing state.
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;

   // Per-slot snapshot of the digit being shown.
   logic [3:0]    data_q, data_d;
   logic          dp_q, dp_d;
   logic          mask_q, mask_d;

   // Blink synchroniser.
   logic          blink_q;

   // Registered outputs.
   logic [3:0]    anode_q, anode_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_out_q, dp_out_d;

   // One-hot digit select, active-high.
   logic [3:0]    onehot;

   // Active-high gfedcba pattern for one BCD digit; non-BCD codes show a dash.
   function automatic logic [6:0] decode(input logic [3:0] bcd);
      logic [6:0] pat;
      pat = 7'h40;
      case (bcd)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h40;
      endcase
      return pat;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_onehot
         assign onehot[gi] = (idx_q == 2'(gi));
      end
   endgenerate

   // Slot counter, digit index and start-of-slot capture of the digit's data.
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      idx_d  = idx_q;
      data_d = data_q;
      dp_d   = dp_q;
      mask_d = mask_q;
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
      // Sampling only at cnt == 0 freezes the slot's content, so inputs that
      // change mid-slot wait for the digit's next turn.
      if (cnt_q == '0) begin
         data_d = digits[4*idx_q +: 4];
         dp_d   = dp_mask[idx_q];
         mask_d = blink_mask[idx_q];
      end
   end

   // Output pattern: dead time first, then the digit (or a blanked digit
   // whose anode still scans so brightness is unaffected by blinking).
   always_comb begin
      logic [3:0] an_act;
      logic [6:0] seg_act;
      logic       dp_act;
      logic       lit;
      logic       blank;
      lit     = (cnt_q >= CW'(DEAD_CYCLES));
      blank   = mask_q && !blink_q;
      an_act  = 4'h0;
      seg_act = 7'h00;
      dp_act  = 1'b0;
      if (lit) begin
         an_act = onehot;
         if (!blank) begin
            seg_act = decode(data_q);
            dp_act  = dp_q;
         end
      end
      anode_d  = ANODE_ACTIVE_LOW ? ~an_act : an_act;
      seg_d    = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
      dp_out_d = SEG_ACTIVE_LOW ? ~dp_act : dp_act;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         dp_q     <= 1'b0;
         mask_q   <= 1'b0;
         blink_q  <= 1'b0;
         anode_q  <= ANODE_OFF;
         seg_q    <= SEG_OFF;
         dp_out_q <= DP_OFF;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         dp_q     <= dp_d;
         mask_q   <= mask_d;
         blink_q  <= blink;
         anode_q  <= anode_d;
         seg_q    <= seg_d;
         dp_out_q <= dp_out_d;
      end
   end

   assign anode = anode_q;
   assign seg   = seg_q;
   assign dp    = dp_out_q;

endmodule

// File: tb/tb_seg7_scan_blink.sv
// Testbench for seg7_scan_blink: random digits, masks, blink and resets, with
// outputs predicted from a history of sampled inputs and slot arithmetic.
module tb_seg7_scan_blink;

   localparam int N1 = 8;
   localparam int D1 = 2;
   localparam int N2 = 5;
   localparam int D2 = 1;
   localparam int MAXH = 4096;
   localparam int CYCLES = 2000;

   localparam logic [6:0] FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
   };

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits = 16'h0;
   logic [3:0]  blink_mask = 4'h0;
   logic        blink = 1'b0;
   logic [3:0]  dp_mask = 4'h0;

   logic [3:0]  anode1, anode2;
   logic [6:0]  seg1, seg2;
   logic        dp1, dp2;

   int checks = 0;
   int errors = 0;
   int j = 0;

   // Inputs as sampled at rising edge number k after the last reset edge.
   logic [15:0] h_dig [MAXH];
   logic [3:0]  h_bm  [MAXH];
   logic [3:0]  h_dpm [MAXH];
   logic        h_blk [MAXH];

   always #5 clk = ~clk;

   seg7_scan_blink #(
      .SCAN_DIV(N1), .DEAD_CYCLES(D1),
      .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .digits(digits), .blink_mask(blink_mask),
      .blink(blink), .dp_mask(dp_mask), .anode(anode1), .seg(seg1), .dp(dp1)
   );

   seg7_scan_blink #(
      .SCAN_DIV(N2), .DEAD_CYCLES(D2),
      .SEG_ACTIVE_LOW(1'b0), .ANODE_ACTIVE_LOW(1'b0)
   ) dut_hi (
      .clk(clk), .reset(reset), .digits(digits), .blink_mask(blink_mask),
      .blink(blink), .dp_mask(dp_mask), .anode(anode2), .seg(seg2), .dp(dp2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d after reset, t=%0t)", tag, got, exp, j, $time);
      end
   endtask

   // Expected outputs after edge k: edge k shows the state held after edge
   // k-1, i.e. slot position (k-1) mod n of digit ((k-1)/n) mod 4, whose data
   // were sampled at the edge that opened that slot.
   function automatic void model(input int k, input int n, input int dead,
                                 input bit sal, input bit aal,
                                 output logic [3:0] a, output logic [6:0] s,
                                 output logic d);
      int c, i, m;
      logic [3:0] dig;
      logic [3:0] an;
      logic [6:0] sg;
      logic       dd;
      logic       blk_seen;
      an = 4'h0;
      sg = 7'h00;
      dd = 1'b0;
      if (k > 0) begin
         c = (k - 1) % n;
         i = ((k - 1) / n) % 4;
         if (c >= dead) begin
            m = k - c;
            dig = h_dig[m][4*i +: 4];
            an = 4'h1 << i;
            blk_seen = (k - 1 >= 1) ? h_blk[k-1] : 1'b0;
            if (!(h_bm[m][i] && !blk_seen)) begin
               sg = FONT[dig];
               dd = h_dpm[m][i];
            end
         end
      end
      a = aal ? ~an : an;
      s = sal ? ~sg : sg;
      d = sal ? ~dd : dd;
   endfunction

   initial begin
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      logic [3:0] act, prev_act;
      int rst_left;
      rst_left = 3;
      prev_act = 4'h0;
      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(negedge clk);
         if (rst_left == 0 && ($urandom_range(0, 249) == 0 || j >= MAXH - 2))
            rst_left = $urandom_range(1, 3);
         reset = (rst_left > 0);
         if (rst_left > 0) rst_left--;
         if ($urandom_range(0, 4) == 0)  digits = 16'($urandom);
         if ($urandom_range(0, 5) == 0)  blink = ~blink;
         if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
         if ($urandom_range(0, 19) == 0) dp_mask = 4'($urandom);
         @(posedge clk);
         if (reset) begin
            j = 0;
         end else begin
            j++;
            h_dig[j] = digits;
            h_bm[j]  = blink_mask;
            h_dpm[j] = dp_mask;
            h_blk[j] = blink;
         end
         #1;
         model(j, N1, D1, 1'b1, 1'b1, ea, es, ed);
         check_eq("anode_lo", 32'(anode1), 32'(ea));
         check_eq("seg_lo", 32'(seg1), 32'(es));
         check_eq("dp_lo", 32'(dp1), 32'(ed));
         model(j, N2, D2, 1'b0, 1'b0, ea, es, ed);
         check_eq("anode_hi", 32'(anode2), 32'(ea));
         check_eq("seg_hi", 32'(seg2), 32'(es));
         check_eq("dp_hi", 32'(dp2), 32'(ed));
         act = ~anode1;
         check_eq("one_anode", 32'($countones(act) <= 1), 32'(1));
         check_eq("dead_gap", 32'(act == 4'h0 || prev_act == 4'h0 || act == prev_act), 32'(1));
         prev_act = act;
         $display("cyc %0d rst=%0b k=%0d dig=%h bm=%h bl=%0b dpm=%h | anode=%b seg=%h dp=%0b",
                  cyc, reset, j, digits, blink_mask, blink, dp_mask, anode1, seg1, dp1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
